dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the memory stage of the pipelined ARM32 core. It receives word load and store requests: address from the ALU result, store data from the register file, and the write enable driven by the memory-stage controller.
- It performs each access after a configurable latency and returns load data or an error through a valid/ready response handshake.
- It exports a busy signal that the pipeline uses as a stall source.
- The backing store is a word-addressed on-chip array.

Parameters:
- ADDR_W, 8, number of word-index bits; array depth is 2**ADDR_W words.
- READ_LATENCY, 1, cycles from request acceptance to rsp_valid for loads; legal range 1..15.
- WRITE_LATENCY, 1, cycles from request acceptance to rsp_valid for stores; legal range 1..15.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  memory stage presents a request
- req_ready  output  1  responder can accept a request this cycle
- req_we  input  1  1 = store (STR), 0 = load (LDR)
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer takes the response this cycle
- rsp_rdata  output  32  load data; 0 for stores and errors
- rsp_err  output  1  request was misaligned or out of range
- rsp_we  output  1  echo of req_we for the returned response
- busy  output  1  responder is not IDLE; pipeline stall source

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_we=0, busy=0, counter=0.
- Array contents are not reset.
- Reset asserted mid-operation aborts the transaction; a pending store not yet committed is dropped.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture addr, we and wdata.
  - Compute lat = we ? WRITE_LATENCY : READ_LATENCY.
  - If lat==1, go to RESP; otherwise load counter=lat-1 and go to WAIT.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - When counter==1, go to RESP on the next edge.
- Access:
  - Performed on the edge entering RESP.
  - Store: array[idx] <= wdata.
  - Load: rsp_rdata <= array[idx].
  - rsp_valid is asserted exactly lat cycles after the accepting edge.
- Error:
  - err = (addr[1:0]!=0) || (addr[31:ADDR_W+2]!=0).
  - An erroring request still follows the normal latency, but the array is untouched, rsp_rdata=0 and rsp_err=1.
- Index: idx = addr[ADDR_W+1:2].
- RESP:
  - rsp_valid=1; rsp_rdata, rsp_err and rsp_we are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE, clear rsp_valid and zero rsp_rdata/rsp_err.
  - req_ready=0 in RESP, so there is no back-to-back overlap; maximum throughput is one request per lat+1 cycles.
- busy = (state != IDLE), registered.
- Requests presented while req_ready=0 are ignored; the requester must hold them.
- A store followed by a load to the same address returns the new data, because the store commits before its response.
- Address wrap: none. Out-of-range addresses error and never alias.
- A wdata change after acceptance has no effect.

Decomposition:
- dmem_pkg holds:
  - the state enum: IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - the latency counter width constant (4 bits);
  - an err_check function of (addr, ADDR_W).
- One sub-module, dmem_array: single-port synchronous word array with we, idx, wdata and a registered rdata, no reset. The responder FSM instantiates it.

Test Plan:
- Reset, then store 0xDEADBEEF to 0x10 and load from 0x10, both at default latency with rsp_ready=1:
  - store response one cycle after accept (rsp_we=1, rsp_err=0);
  - load returns rsp_rdata=0xDEADBEEF.
- READ_LATENCY=4, load from 0x20:
  - rsp_valid rises exactly 4 cycles after accept;
  - busy=1 and req_ready=0 for cycles 1..4.
- Misaligned store to 0x13 with data 0x12345678:
  - rsp_err=1, rsp_rdata=0;
  - a subsequent load from 0x10 still returns the prior contents.
- Out-of-range load from 0x0000_0400 with ADDR_W=8: rsp_err=1, rsp_rdata=0.
- Backpressure:
  - hold rsp_ready=0 for 5 cycles after rsp_valid: rsp_valid and rsp_rdata stay stable, and a new req_valid is not accepted;
  - raise rsp_ready: the FSM returns to IDLE next cycle.
- Assert rst_n=0 during WAIT of a store to 0x30 (WRITE_LATENCY=3):
  - outputs return to reset values;
  - after reset, a load from 0x30 returns the pre-store value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder of the ARM32 memory stage.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Wide enough for the largest latency (15).
  localparam int CNT_W = 4;

  // A request errors when it is not word aligned or addresses beyond the array.
  function automatic logic err_check(input logic [31:0] addr, input int addr_w);
    logic [31:0] hi_bits;
    hi_bits = addr >> (addr_w + 2);
    return (addr[1:0] != 2'b00) || (hi_bits != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake between the memory stage and the data-memory responder.
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_we;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_we, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_we, busy
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word array with registered read data.
module dmem_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // NOTE: no reset on the storage or read register; a reset would force the array into flops.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[idx] <= wdata;
      else    rdata    <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency word load/store with valid/ready response and busy stall.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int READ_LATENCY  = 1,
  parameter int WRITE_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_responder_if.slave   bus
);

  localparam logic [CNT_W-1:0] RD_LAT = CNT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0] WR_LAT = CNT_W'(WRITE_LATENCY);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] lat;
  logic [31:0]      addr_q, wdata_q;
  logic             we_q, busy_q;
  logic             accept, enter_resp;
  logic [31:0]      cur_addr, cur_wdata;
  logic             cur_we, cur_err, resp_err;
  logic [31:0]      arr_rdata;

  assign accept = (state == IDLE) && bus.req_valid;
  assign lat    = bus.req_we ? WR_LAT : RD_LAT;

  // A latency-1 access happens on the accepting edge, before the request is captured,
  // so the array must see the live request while IDLE.
  assign cur_addr  = (state == IDLE) ? bus.req_addr  : addr_q;
  assign cur_wdata = (state == IDLE) ? bus.req_wdata : wdata_q;
  assign cur_we    = (state == IDLE) ? bus.req_we    : we_q;
  assign cur_err   = err_check(cur_addr, ADDR_W);
  assign resp_err  = err_check(addr_q, ADDR_W);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (lat == CNT_W'(1)) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = lat - CNT_W'(1);
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      busy_q <= (state_nxt != IDLE);
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        we_q    <= bus.req_we;
      end
    end
  end

  // Erroring requests never touch the array; an aborted store never reaches enter_resp.
  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .en    (enter_resp && !cur_err),
    .we    (cur_we),
    .idx   (cur_addr[ADDR_W+1:2]),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = ((state == RESP) && !we_q && !resp_err) ? arr_rdata : 32'd0;
  assign bus.rsp_err   = (state == RESP) && resp_err;
  assign bus.rsp_we    = (state == RESP) && we_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (latency 1/1 and read 4 / write 3).
module tb_dmem_responder;

  localparam int DEPTH = 256;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    bit          we;
    int          lat;
    int          acc_cyc;
    bit          chk_data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  dmem_responder #(.ADDR_W(8), .READ_LATENCY(1), .WRITE_LATENCY(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  dmem_responder #(.ADDR_W(8), .READ_LATENCY(4), .WRITE_LATENCY(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  bit          sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        dir_rdy = 1'b1;
  logic        rnd_rdy = 1'b1;
  bit          rand_rdy_en = 1'b0;
  logic        rsp_ready;

  assign rsp_ready       = rand_rdy_en ? rnd_rdy : dir_rdy;
  assign bus0.req_valid  = req_valid && !sel;
  assign bus1.req_valid  = req_valid && sel;
  assign bus0.req_we     = req_we;
  assign bus1.req_we     = req_we;
  assign bus0.req_addr   = req_addr;
  assign bus1.req_addr   = req_addr;
  assign bus0.req_wdata  = req_wdata;
  assign bus1.req_wdata  = req_wdata;
  assign bus0.rsp_ready  = rsp_ready;
  assign bus1.rsp_ready  = rsp_ready;

  logic        m_req_ready, m_rsp_valid, m_rsp_err, m_rsp_we, m_busy;
  logic [31:0] m_rsp_rdata;
  assign m_req_ready = sel ? bus1.req_ready : bus0.req_ready;
  assign m_rsp_valid = sel ? bus1.rsp_valid : bus0.rsp_valid;
  assign m_rsp_rdata = sel ? bus1.rsp_rdata : bus0.rsp_rdata;
  assign m_rsp_err   = sel ? bus1.rsp_err   : bus0.rsp_err;
  assign m_rsp_we    = sel ? bus1.rsp_we    : bus0.rsp_we;
  assign m_busy      = sel ? bus1.busy      : bus0.busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb[$];

  logic [31:0] mdl   [2][DEPTH];
  bit          known [2][DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: checks response latency on rsp_valid's rise, contents on each handshake.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_rsp_valid && !prev_v && sb.size() != 0)
        check("rsp_latency", 32'(cyc - sb[0].acc_cyc + 1), 32'(sb[0].lat));
      if (m_rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_without_request", 32'(m_rsp_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.chk_data) check("rsp_rdata", m_rsp_rdata, e.rdata);
          check("rsp_err", 32'(m_rsp_err), 32'(e.err));
          check("rsp_we", 32'(m_rsp_we), 32'(e.we));
        end
      end
    end
    prev_v <= m_rsp_valid;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 rnd_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Presents one request, waits (bounded) for acceptance, then records the expectation.
  task automatic issue(input bit s, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit expect_rsp);
    int   n;
    exp_t e;
    int   w;
    if (s != sel) wait_drain();
    @(posedge clk);
    #1;
    sel = s; req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (m_req_ready) break;
      n++;
      if (n >= 100) begin
        check("accept_timeout", 32'(m_req_ready), 32'd1);
        req_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = ~wdata;
    if (!expect_rsp) return;
    e.we       = we;
    e.lat      = s ? (we ? 3 : 4) : 1;
    e.acc_cyc  = cyc;
    e.err      = ((addr % 4) != 0) || (addr >= 32'(4 * DEPTH));
    e.rdata    = 32'd0;
    e.chk_data = 1'b1;
    if (!e.err) begin
      w = int'(addr / 4);
      if (we) begin
        mdl[s][w]   = wdata;
        known[s][w] = 1'b1;
      end else begin
        e.rdata    = mdl[s][w];
        e.chk_data = known[s][w];
      end
    end
    sb.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(m_req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(m_rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, m_rsp_rdata, 32'd0);
    check({tag, "_rsp_err"},   32'(m_rsp_err),   32'd0);
    check({tag, "_rsp_we"},    32'(m_rsp_we),    32'd0);
    check({tag, "_busy"},      32'(m_busy),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] a;
    int r;

    // Reset values on both instances.
    #3;
    sel = 1'b0; #1 check_reset_outputs("reset0");
    sel = 1'b1; #1 check_reset_outputs("reset1");
    sel = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Store then load at latency 1.
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 1'b1);
    // Misaligned store leaves the array untouched.
    issue(1'b0, 1'b1, 32'h13, 32'h12345678, 1'b1);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 1'b1);
    // Out-of-range load.
    issue(1'b0, 1'b0, 32'h0000_0400, 32'h0, 1'b1);
    wait_drain();

    // Backpressure: response must hold, and a new request must be refused.
    dir_rdy = 1'b0;
    issue(1'b0, 1'b0, 32'h10, 32'h0, 1'b1);
    req_addr = 32'h14; req_we = 1'b0; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!m_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(m_rsp_valid), 32'd1);
      check("bp_rsp_rdata", m_rsp_rdata, 32'hDEADBEEF);
      check("bp_req_ready", 32'(m_req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    dir_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_busy", 32'(m_busy), 32'd0);
    check("bp_idle_req_ready", 32'(m_req_ready), 32'd1);
    check("bp_idle_rsp_valid", 32'(m_rsp_valid), 32'd0);
    wait_drain();

    // Read latency 4: busy and not ready for the whole wait.
    issue(1'b1, 1'b1, 32'h20, 32'hCAFE0020, 1'b1);
    issue(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("lat4_busy", 32'(m_busy), 32'd1);
      check("lat4_req_ready", 32'(m_req_ready), 32'd0);
    end
    wait_drain();

    // Reset during WAIT of a store drops the store.
    issue(1'b1, 1'b1, 32'h30, 32'hA5A50030, 1'b1);
    wait_drain();
    issue(1'b1, 1'b1, 32'h30, 32'h0BAD0BAD, 1'b0);
    @(negedge clk);
    check("abort_busy_before", 32'(m_busy), 32'd1);
    rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 1'b0, 32'h30, 32'h0, 1'b1);
    wait_drain();

    // Randomized traffic with random backpressure on both instances.
    rand_rdy_en = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 16; w++)
        issue(s[0], 1'b1, 32'(w * 4), $urandom, 1'b1);
      for (int k = 0; k < 40; k++) begin
        r = int'($urandom_range(0, 9));
        if (r < 8)       a = 32'($urandom_range(0, 15)) << 2;
        else if (r == 8) a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
        else begin
          a = $urandom & 32'hFFFF_FC00;
          if (a == 32'd0) a = 32'h400;
        end
        issue(s[0], $urandom_range(0, 1) == 1, a, $urandom, 1'b1);
      end
      wait_drain();
    end
    rand_rdy_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
